board_lineclear: RTL and testbench

//  Parametrised successor to the settled-cell store of the playfield. Holds locked tetromino cells
//  in an X_SIZE x Y_SIZE array, answers combinational collision queries for a candidate 4-cell placement,
//  and, on a lock handshake, writes the piece, then scans the board, removes full rows and compacts downward.
//  The active (falling) piece is not stored here; the renderer overlays it. Row 0 is top, y grows downward.

---
 rtl/board_lineclear.sv | 227 ++++++++++++++++++++++
 tb/tb_board_lineclear.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_lineclear.sv
// ---------------------------------------------------------------------------
// board_lineclear
//   Settled-cell store of the playfield. Holds locked tetromino cells in an
//   X_SIZE x Y_SIZE array (row 0 at the top, y grows downward). It answers
//   combinational collision queries for a candidate 4-cell piece. A lock
//   handshake writes a piece into the array. The block then scans the board
//   bottom-up, drops full rows, compacts the rest downward and blanks the
//   rows freed at the top. The falling piece is not stored here.
//
// Ports
//   Clk, Reset_n              clock, asynchronous active-low reset
//   rd_x/rd_y -> rd_color     display read port (comb), 0 when out of range
//   chk_x/chk_y -> chk_ok     candidate piece (cell i at [i*W +: W]);
//                             1 when all cells are free and the FSM is idle
//   lock_valid/lock_ready     lock handshake for lock_x/lock_y/lock_color
//   clear                     synchronous new-game clear (wins over lock)
//   busy, done                sequence running / one-cycle completion pulse
//   lines_cleared             rows removed by the last lock, held between pulses
//   total_lines               cumulative rows removed, saturating
//   top_out                   sticky flag: a lock collided or was out of range
// ---------------------------------------------------------------------------
module board_lineclear #(
    parameter int X_SIZE = 10,
    parameter int Y_SIZE = 20,
    parameter int CW     = 3,
    parameter int XW     = 5,
    parameter int YW     = 5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [XW-1:0]     rd_x,
    input  logic [YW-1:0]     rd_y,
    output logic [CW-1:0]     rd_color,
    input  logic [4*XW-1:0]   chk_x,
    input  logic [4*YW-1:0]   chk_y,
    output logic              chk_ok,
    input  logic              lock_valid,
    output logic              lock_ready,
    input  logic [4*XW-1:0]   lock_x,
    input  logic [4*YW-1:0]   lock_y,
    input  logic [CW-1:0]     lock_color,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic [2:0]        lines_cleared,
    output logic [15:0]       total_lines,
    output logic              top_out
);

    localparam int XIW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int RW  = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

    localparam logic [XW-1:0] X_LIM    = XW'(X_SIZE);
    localparam logic [YW-1:0] Y_LIM    = YW'(Y_SIZE);
    localparam logic [RW-1:0] ROW_LAST = RW'(Y_SIZE - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SCAN, S_FILL, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     board_q [Y_SIZE][X_SIZE];
    logic [CW-1:0]     board_d [Y_SIZE][X_SIZE];
    logic [4*XW-1:0]   lx_q, lx_d;
    logic [4*YW-1:0]   ly_q, ly_d;
    logic [CW-1:0]     lcol_q, lcol_d;
    logic [RW-1:0]     rd_row_q, rd_row_d;
    logic [RW-1:0]     wr_row_q, wr_row_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        lines_q, lines_d;
    logic [15:0]       total_q, total_d;
    logic              top_out_q, top_out_d;

    logic [16:0]       total_sum;
    logic [15:0]       total_sat;
    logic              write_ok;
    logic              row_full;
    logic              chk_free;

    function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x < X_LIM) && (y < Y_LIM);
    endfunction

    function automatic logic [CW-1:0] cell_val(input logic [XW-1:0] x, input logic [YW-1:0] y);
        if (in_range(x, y))
            return board_q[y[RW-1:0]][x[XIW-1:0]];
        return '0;
    endfunction

    function automatic logic cell_free(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return in_range(x, y) && (cell_val(x, y) == '0);
    endfunction

    // ---------------- outputs ----------------
    assign rd_color   = cell_val(rd_x, rd_y);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign lock_ready = (state_q == S_IDLE) && !top_out_q;
    assign top_out    = top_out_q;

    // The running total is presented already updated while done is high.
    assign total_sum     = {1'b0, total_q} + {14'd0, cnt_q};
    assign total_sat     = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    assign total_lines   = done ? total_sat : total_q;
    assign lines_cleared = done ? cnt_q : lines_q;

    always_comb begin
        chk_free = 1'b1;
        for (int i = 0; i < 4; i++)
            if (!cell_free(chk_x[i*XW +: XW], chk_y[i*YW +: YW]))
                chk_free = 1'b0;
    end

    assign chk_ok = chk_free && (state_q == S_IDLE);

    // ---------------- next-state ----------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        board_d   = board_q;
        lx_d      = lx_q;
        ly_d      = ly_q;
        lcol_d    = lcol_q;
        rd_row_d  = rd_row_q;
        wr_row_d  = wr_row_q;
        cnt_d     = cnt_q;
        lines_d   = lines_q;
        total_d   = total_q;
        top_out_d = top_out_q;
        write_ok  = 1'b1;
        row_full  = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (lock_valid && lock_ready) begin
                    lx_d    = lock_x;
                    ly_d    = lock_y;
                    lcol_d  = lock_color;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                for (int i = 0; i < 4; i++)
                    if (!cell_free(lx_q[i*XW +: XW], ly_q[i*YW +: YW]))
                        write_ok = 1'b0;
                cnt_d = '0;
                if (write_ok) begin
                    // Duplicate coordinates simply rewrite the same cell.
                    for (int i = 0; i < 4; i++)
                        board_d[ly_q[i*YW +: RW]][lx_q[i*XW +: XIW]] = lcol_q;
                    rd_row_d = ROW_LAST;
                    wr_row_d = ROW_LAST;
                    state_d  = S_SCAN;
                end else begin
                    top_out_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_SCAN: begin
                for (int x = 0; x < X_SIZE; x++)
                    if (board_q[rd_row_q][x] == '0)
                        row_full = 1'b0;
                // wr_row never falls below rd_row, so rows still to be read are never overwritten.
                if (row_full) begin
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    board_d[wr_row_q] = board_q[rd_row_q];
                    wr_row_d          = wr_row_q - ROW_ONE;
                end
                if (rd_row_q == '0)
                    state_d = (cnt_d != '0) ? S_FILL : S_DONE;
                else
                    rd_row_d = rd_row_q - ROW_ONE;
            end
            S_FILL: begin
                // After the scan wr_row points at row cnt-1; blank downward to row 0.
                board_d[wr_row_q] = '{default: '0};
                wr_row_d          = wr_row_q - ROW_ONE;
                if (wr_row_q == '0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                lines_d = cnt_q;
                total_d = total_sat;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            board_d   = '{default: '0};
            top_out_d = 1'b0;
            state_d   = S_IDLE;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            // NOTE: the cell array is real flops and must be reset; the board has to read empty straight out of reset.
            board_q   <= '{default: '0};
            lx_q      <= '0;
            ly_q      <= '0;
            lcol_q    <= '0;
            rd_row_q  <= '0;
            wr_row_q  <= '0;
            cnt_q     <= '0;
            lines_q   <= '0;
            total_q   <= '0;
            top_out_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            state_q   <= state_d;
            board_q   <= board_d;
            lx_q      <= lx_d;
            ly_q      <= ly_d;
            lcol_q    <= lcol_d;
            rd_row_q  <= rd_row_d;
            wr_row_q  <= wr_row_d;
            cnt_q     <= cnt_d;
            lines_q   <= lines_d;
            total_q   <= total_d;
            top_out_q <= top_out_d;
        end
    end

endmodule

// File: tb/tb_board_lineclear.sv
// ---------------------------------------------------------------------------
// tb_board_lineclear
//   Directed bench for board_lineclear. It builds board contents through
//   lock handshakes and compares every observation with a hand-computed value.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_board_lineclear;

    localparam int XS = 10;
    localparam int YS = 20;
    localparam int CW = 3;
    localparam int XW = 5;
    localparam int YW = 5;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic [XW-1:0]     rd_x = '0;
    logic [YW-1:0]     rd_y = '0;
    logic [CW-1:0]     rd_color;
    logic [4*XW-1:0]   chk_x = '0;
    logic [4*YW-1:0]   chk_y = '0;
    logic              chk_ok;
    logic              lock_valid = 1'b0;
    logic              lock_ready;
    logic [4*XW-1:0]   lock_x = '0;
    logic [4*YW-1:0]   lock_y = '0;
    logic [CW-1:0]     lock_color = '0;
    logic              clear = 1'b0;
    logic              busy;
    logic              done;
    logic [2:0]        lines_cleared;
    logic [15:0]       total_lines;
    logic              top_out;

    int tests = 0;
    int fails = 0;

    board_lineclear #(.X_SIZE(XS), .Y_SIZE(YS), .CW(CW), .XW(XW), .YW(YW)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .rd_color      (rd_color),
        .chk_x         (chk_x),
        .chk_y         (chk_y),
        .chk_ok        (chk_ok),
        .lock_valid    (lock_valid),
        .lock_ready    (lock_ready),
        .lock_x        (lock_x),
        .lock_y        (lock_y),
        .lock_color    (lock_color),
        .clear         (clear),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines),
        .top_out       (top_out)
    );

    always #5 Clk = ~Clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Packs four coordinates, cell 0 in the low field.
    function automatic logic [4*XW-1:0] p4(input int a, input int b, input int c, input int d);
        return {XW'(d), XW'(c), XW'(b), XW'(a)};
    endfunction

    task automatic read_cell(input int x, input int y, output logic [CW-1:0] c);
        rd_x = XW'(x);
        rd_y = YW'(y);
        #1;
        c = rd_color;
    endtask

    task automatic count_cells(output int n);
        logic [CW-1:0] c;
        n = 0;
        for (int y = 0; y < YS; y++)
            for (int x = 0; x < XS; x++) begin
                read_cell(x, y, c);
                if (c != '0) n++;
            end
    endtask

    task automatic pulse_clear();
        @(negedge Clk);
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
    endtask

    // Locks a piece and reports the latency: falling edges from the
    // handshake edge up to and including the one where done is seen.
    task automatic do_lock(input logic [4*XW-1:0] xs, input logic [4*YW-1:0] ys,
                           input logic [CW-1:0] col, output int lat,
                           output logic [2:0] lines, output logic [15:0] tot);
        int waitc;
        lat   = 0;
        lines = '0;
        tot   = '0;
        @(negedge Clk);
        lock_x     = xs;
        lock_y     = ys;
        lock_color = col;
        lock_valid = 1'b1;
        waitc      = 0;
        while (!lock_ready && waitc < 50) begin
            @(negedge Clk);
            waitc++;
        end
        if (!lock_ready) begin
            check("handshake_timeout", {31'd0, lock_ready}, 1);
            lock_valid = 1'b0;
            return;
        end
        @(posedge Clk);
        #1 lock_valid = 1'b0;
        while (lat < 100) begin
            @(negedge Clk);
            lat++;
            if (done) break;
        end
        if (!done) check("done_timeout", {31'd0, done}, 1);
        lines = lines_cleared;
        tot   = total_lines;
    endtask

    initial begin
        int            n;
        int            lat;
        logic [2:0]    lines;
        logic [15:0]   tot;
        logic [CW-1:0] c;

        // ---------------- 1: reset ----------------
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        count_cells(n);
        check("reset_cells", n, 0);
        check("reset_busy", busy, 0);
        check("reset_lock_ready", lock_ready, 1);
        check("reset_total", total_lines, 0);
        check("reset_top_out", top_out, 0);
        check("reset_done", done, 0);
        chk_x = p4(0, 1, 2, 3);
        chk_y = p4(19, 19, 19, 19);
        #1 check("reset_chk_I_row19", chk_ok, 1);

        // ---------------- 2: simple lock ----------------
        do_lock(p4(0, 1, 2, 3), p4(19, 19, 19, 19), 3'd1, lat, lines, tot);
        check("t2_latency", lat, 22);
        check("t2_lines", lines, 0);
        @(negedge Clk);
        check("t2_done_pulse", done, 0);
        for (int x = 0; x < 4; x++) begin
            read_cell(x, 19, c);
            check("t2_cell_row19", c, 1);
        end
        read_cell(4, 19, c);
        check("t2_cell_4_19", c, 0);
        #1 check("t2_chk_occupied", chk_ok, 0);

        // ---------------- 3: single line clear ----------------
        pulse_clear();
        do_lock(p4(0, 1, 2, 3), p4(19, 19, 19, 19), 3'd2, lat, lines, tot);
        do_lock(p4(4, 5, 5, 5), p4(19, 19, 19, 19), 3'd2, lat, lines, tot);
        do_lock(p4(0, 0, 0, 0), p4(18, 18, 18, 18), 3'd3, lat, lines, tot);
        do_lock(p4(6, 7, 8, 9), p4(19, 19, 19, 19), 3'd1, lat, lines, tot);
        check("t3_latency", lat, 23);
        check("t3_lines", lines, 1);
        check("t3_total", tot, 1);
        read_cell(0, 19, c);
        check("t3_cell_0_19", c, 3);
        count_cells(n);
        check("t3_cell_count", n, 1);
        check("t3_lines_held", lines_cleared, 1);
        check("t3_total_held", total_lines, 1);

        // ---------------- 4: four-line clear ----------------
        pulse_clear();
        for (int r = 16; r < 20; r++) begin
            do_lock(p4(0, 1, 2, 3), p4(r, r, r, r), 3'd4, lat, lines, tot);
            do_lock(p4(4, 5, 6, 7), p4(r, r, r, r), 3'd4, lat, lines, tot);
            do_lock(p4(8, 8, 8, 8), p4(r, r, r, r), 3'd4, lat, lines, tot);
        end
        do_lock(p4(4, 4, 4, 4), p4(15, 15, 15, 15), 3'd5, lat, lines, tot);
        do_lock(p4(9, 9, 9, 9), p4(16, 17, 18, 19), 3'd6, lat, lines, tot);
        check("t4_latency", lat, 26);
        check("t4_lines", lines, 4);
        check("t4_total", tot, 5);
        read_cell(4, 19, c);
        check("t4_marker", c, 5);
        count_cells(n);
        check("t4_cell_count", n, 1);

        // ---------------- 5: collision, top_out, clear ----------------
        do_lock(p4(4, 5, 6, 7), p4(19, 19, 19, 19), 3'd7, lat, lines, tot);
        check("t5_latency", lat, 2);
        check("t5_lines", lines, 0);
        @(negedge Clk);
        check("t5_top_out", top_out, 1);
        check("t5_lock_ready", lock_ready, 0);
        check("t5_total", total_lines, 5);
        count_cells(n);
        check("t5_cell_count", n, 1);
        read_cell(4, 19, c);
        check("t5_marker", c, 5);
        @(negedge Clk);
        lock_x     = p4(0, 1, 2, 3);
        lock_y     = p4(0, 0, 0, 0);
        lock_color = 3'd2;
        lock_valid = 1'b1;
        repeat (4) @(negedge Clk);
        check("t5_ignored_busy", busy, 0);
        lock_valid = 1'b0;
        read_cell(0, 0, c);
        check("t5_ignored_cell", c, 0);
        pulse_clear();
        check("t5_clear_top_out", top_out, 0);
        check("t5_clear_lock_ready", lock_ready, 1);
        check("t5_clear_total_kept", total_lines, 5);
        check("t5_clear_no_done", done, 0);
        count_cells(n);
        check("t5_clear_cells", n, 0);

        // clear and lock in the same cycle: clear wins
        @(negedge Clk);
        clear      = 1'b1;
        lock_valid = 1'b1;
        @(negedge Clk);
        clear      = 1'b0;
        lock_valid = 1'b0;
        check("clear_vs_lock_busy", busy, 0);
        repeat (2) @(negedge Clk);
        read_cell(0, 0, c);
        check("clear_vs_lock_cell", c, 0);

        // lock with a cell below the board
        do_lock(p4(0, 1, 2, 3), p4(17, 18, 19, 20), 3'd1, lat, lines, tot);
        check("oor_latency", lat, 2);
        check("oor_lines", lines, 0);
        @(negedge Clk);
        check("oor_top_out", top_out, 1);
        count_cells(n);
        check("oor_cells", n, 0);
        pulse_clear();

        // ---------------- 6: chk bounds, chk while busy, reset mid-scan ----------------
        chk_x = p4(7, 8, 9, 10);
        chk_y = p4(19, 19, 19, 19);
        #1 check("t6_chk_x10", chk_ok, 0);
        chk_x = p4(0, 1, 2, 3);
        chk_y = p4(17, 18, 19, 20);
        #1 check("t6_chk_y20", chk_ok, 0);
        chk_x = p4(6, 7, 8, 9);
        chk_y = p4(19, 19, 19, 19);
        #1 check("t6_chk_x9_edge", chk_ok, 1);

        @(negedge Clk);
        lock_x     = p4(0, 1, 2, 3);
        lock_y     = p4(19, 19, 19, 19);
        lock_color = 3'd1;
        lock_valid = 1'b1;
        @(posedge Clk);
        #1 lock_valid = 1'b0;
        repeat (5) @(negedge Clk);
        check("t6_scan_busy", busy, 1);
        chk_x = p4(0, 1, 2, 3);
        chk_y = p4(0, 0, 0, 0);
        #1 check("t6_chk_during_scan", chk_ok, 0);
        Reset_n = 1'b0;
        #1;
        check("t6_reset_busy", busy, 0);
        check("t6_reset_total", total_lines, 0);
        count_cells(n);
        check("t6_reset_cells", n, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("t6_release_lock_ready", lock_ready, 1);
        check("t6_release_chk_ok", chk_ok, 1);
        check("t6_release_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
